// File: rtl/lsu_stage.sv
// Memory-access stage: turns a load/store in MEM into one or two word-aligned
// valid/ready requests, stalls the pipeline until the access completes, and
// presents right-justified raw load data to MEM/WB.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no access in flight; a new op drives the low request directly
// REQ_LO  | low-word request waiting for i_dmem_ready
// WAIT_LO | low-word request accepted, waiting for its response
// REQ_HI  | high-word request (boundary-crossing access) waiting for ready
// WAIT_HI | high-word request accepted, waiting for its response
// DONE    | result/fault valid; held while i_hold is asserted
module lsu_stage #(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_hold,
  output logic        o_stall,
  output logic [31:0] o_rdata,
  output logic        o_fault,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_ready,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ_LO  = 3'd1;
  localparam logic [2:0] ST_WAIT_LO = 3'd2;
  localparam logic [2:0] ST_REQ_HI  = 3'd3;
  localparam logic [2:0] ST_WAIT_HI = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  // Sign/zero extension lives in writeback, so funct3[2] is not needed here.
  logic funct3_unused;
  assign funct3_unused = i_funct3[2];

  logic        op;
  logic [1:0]  off;
  logic [3:0]  size_mask;
  logic [7:0]  lane_mask;
  logic [63:0] wdata64;
  logic [31:0] base;
  logic        crossing;

  logic [2:0]  state_q,  state_d;
  logic [31:0] base_q,   base_d;
  logic [1:0]  off_q,    off_d;
  logic        we_q,     we_d;
  logic        cross_q,  cross_d;
  logic [3:0]  be_lo_q,  be_lo_d;
  logic [3:0]  be_hi_q,  be_hi_d;
  logic [31:0] wd_lo_q,  wd_lo_d;
  logic [31:0] wd_hi_q,  wd_hi_d;
  logic [31:0] lo_buf_q, lo_buf_d;
  logic [31:0] rdata_q,  rdata_d;
  logic        fault_q,  fault_d;

  logic        req;
  logic        stall;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  // Select 32 bits of a {hi, lo} word pair starting at the addressed byte.
  function automatic logic [31:0] align_load(input logic [63:0] pair,
                                             input logic [1:0]  sh);
    return pair[{sh, 3'b000} +: 32];
  endfunction

  // Decode the incoming access: lane mask, shifted store data, boundary check.
  always_comb begin
    op = i_valid & (i_mem_read | i_mem_write);
    off = i_addr[1:0];
    case (i_funct3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    lane_mask = {4'b0000, size_mask} << off;
    wdata64 = {32'h0, i_wdata} << {off, 3'b000};
    base = {i_addr[31:2], 2'b00};
    crossing = |lane_mask[7:4];
  end

  // Access sequencer: request issue, response collection and result build.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    off_d     = off_q;
    we_d      = we_q;
    cross_d   = cross_q;
    be_lo_d   = be_lo_q;
    be_hi_d   = be_hi_q;
    wd_lo_d   = wd_lo_q;
    wd_hi_d   = wd_hi_q;
    lo_buf_d  = lo_buf_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;
    req       = 1'b0;
    stall     = 1'b0;
    req_we    = we_q;
    req_addr  = base_q;
    req_wdata = wd_lo_q;
    req_be    = 4'b0000;

    case (state_q)
      ST_IDLE: begin
        if (op) begin
          stall   = 1'b1;
          base_d  = base;
          off_d   = off;
          we_d    = i_mem_write;
          cross_d = crossing;
          be_lo_d = i_mem_write ? lane_mask[3:0] : 4'b0000;
          be_hi_d = i_mem_write ? lane_mask[7:4] : 4'b0000;
          wd_lo_d = wdata64[31:0];
          wd_hi_d = wdata64[63:32];
          if (crossing && !SPLIT_MISALIGNED) begin
            fault_d = 1'b1;
            rdata_d = 32'h0;
            state_d = ST_DONE;
          end else begin
            // Low request goes out in the same cycle the op is seen.
            req       = 1'b1;
            req_we    = i_mem_write;
            req_addr  = base;
            req_wdata = wdata64[31:0];
            req_be    = i_mem_write ? lane_mask[3:0] : 4'b0000;
            state_d   = i_dmem_ready ? ST_WAIT_LO : ST_REQ_LO;
          end
        end
      end
      ST_REQ_LO: begin
        stall     = 1'b1;
        req       = 1'b1;
        req_addr  = base_q;
        req_wdata = wd_lo_q;
        req_be    = be_lo_q;
        if (i_dmem_ready) begin
          state_d = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        stall = 1'b1;
        if (i_dmem_rvalid) begin
          lo_buf_d = i_dmem_rdata;
          if (cross_q) begin
            state_d = ST_REQ_HI;
          end else begin
            rdata_d = we_q ? 32'h0 : align_load({32'h0, i_dmem_rdata}, off_q);
            state_d = ST_DONE;
          end
        end
      end
      ST_REQ_HI: begin
        stall     = 1'b1;
        req       = 1'b1;
        req_addr  = base_q + 32'd4;
        req_wdata = wd_hi_q;
        req_be    = be_hi_q;
        if (i_dmem_ready) begin
          state_d = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        stall = 1'b1;
        if (i_dmem_rvalid) begin
          rdata_d = we_q ? 32'h0 : align_load({i_dmem_rdata, lo_buf_q}, off_q);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!i_hold) begin
          fault_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset drops any access in flight.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      base_q   <= 32'h0;
      off_q    <= 2'b00;
      we_q     <= 1'b0;
      cross_q  <= 1'b0;
      be_lo_q  <= 4'b0000;
      be_hi_q  <= 4'b0000;
      wd_lo_q  <= 32'h0;
      wd_hi_q  <= 32'h0;
      lo_buf_q <= 32'h0;
      rdata_q  <= 32'h0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      off_q    <= off_d;
      we_q     <= we_d;
      cross_q  <= cross_d;
      be_lo_q  <= be_lo_d;
      be_hi_q  <= be_hi_d;
      wd_lo_q  <= wd_lo_d;
      wd_hi_q  <= wd_hi_d;
      lo_buf_q <= lo_buf_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
    end
  end

  // IDLE drives the request combinationally from inputs, so gate the
  // handshake outputs while reset is held.
  always_comb begin
    o_dmem_req   = req & i_reset;
    o_stall      = stall & i_reset;
    o_dmem_we    = req_we;
    o_dmem_addr  = req_addr;
    o_dmem_wdata = req_wdata;
    o_dmem_be    = req_be;
    o_rdata      = rdata_q;
    o_fault      = fault_q;
  end

endmodule
